// File: rtl/servo_seq_multi_if.sv
// rtl/servo_seq_multi_if.sv - pulse-width table write bus for servo_seq_multi
// Purpose: groups the table write strobe with its channel, entry and data.
// Signals:
//   wr_en    table write strobe (commits on the clk edge)
//   wr_ch    channel to write; values >= NUM_CH are ignored by the slave
//   wr_idx   table entry to write
//   wr_data  pulse width in PWM ticks
// Modports: master drives the bus, slave (servo_seq_multi) receives it.
interface servo_seq_multi_if #(
  parameter int NUM_CH     = 2,
  parameter int NUM_ANGLES = 4,
  parameter int W_W        = 8
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = $clog2(NUM_ANGLES);

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [IDX_W-1:0] wr_idx;
  logic [W_W-1:0]   wr_data;

  modport master (output wr_en, wr_ch, wr_idx, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_idx, wr_data);
endinterface

// File: rtl/servo_seq_multi.sv
// rtl/servo_seq_multi.sv - multi-channel servo PWM generator with angle sequencer
// Purpose: per channel, walks a writable pulse-width table at a programmable
// dwell rate (loop or ping-pong) and drives a frame-synchronous PWM output.
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   enable       per-channel enable: gates pwm_out and runs the sequencer
//   mode         per-channel sequence mode: 0 = loop, 1 = ping-pong
//   speed        per-channel dwell code, channel c at [c*SPD_W +: SPD_W]
//   wr           table write bus (slave modport)
//   pwm_out      registered PWM outputs
//   angle_idx    current table index per channel
//   frame_start  one-clk pulse on the first tick of each frame
module servo_seq_multi #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 10_000,
  parameter int STEP_HZ      = 10,
  parameter int PERIOD_TICKS = 200,
  parameter int NUM_CH       = 2,
  parameter int NUM_ANGLES   = 4,
  parameter int W_W          = 8,
  parameter int SPD_W        = 3,
  parameter int RESET_W      = 15
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    enable,
  input  logic [NUM_CH-1:0]                    mode,
  input  logic [NUM_CH*SPD_W-1:0]              speed,
  servo_seq_multi_if.slave                     wr,
  output logic [NUM_CH-1:0]                    pwm_out,
  output logic [NUM_CH*$clog2(NUM_ANGLES)-1:0] angle_idx,
  output logic                                 frame_start
);
  localparam int IDX_W    = $clog2(NUM_ANGLES);
  localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam int STEP_DIV = (TICK_HZ / STEP_HZ > 0) ? TICK_HZ / STEP_HZ : 1;
  localparam int TC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int FC_W     = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int WL_W     = $clog2(PERIOD_TICKS + 1);
  localparam int D_W      = SPD_W + 2;   // holds 2*(2^SPD_W) without overflow

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_ADVANCE} seq_state_t;

  // ---------------- prescalers ----------------
  logic [TC_W-1:0] tick_cnt;
  logic [SC_W-1:0] step_cnt;
  logic            tick;
  logic            step;

  assign tick = (tick_cnt == TC_W'(TICK_DIV - 1));
  assign step = tick & (step_cnt == SC_W'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      step_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TC_W'(1);
      if (tick) step_cnt <= step ? '0 : step_cnt + SC_W'(1);
    end
  end

  // ---------------- frame counter ----------------
  // running is clear until the first tick after reset, so that tick is
  // treated as a wrap: it starts frame 0 and latches the widths.
  logic            running;
  logic [FC_W-1:0] frame_cnt;
  logic            frame_wrap;

  assign frame_wrap = tick & (~running | (frame_cnt == FC_W'(PERIOD_TICKS - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      running     <= 1'b0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (tick) begin
        running   <= 1'b1;
        frame_cnt <= frame_wrap ? '0 : frame_cnt + FC_W'(1);
      end
    end
  end

  // ---------------- width table ----------------
  logic [W_W-1:0] width_tbl [NUM_CH][NUM_ANGLES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int a = 0; a < NUM_ANGLES; a++)
          width_tbl[c][a] <= W_W'(RESET_W);
    end else if (wr.wr_en && (32'(wr.wr_ch) < NUM_CH)) begin
      width_tbl[wr.wr_ch][wr.wr_idx] <= wr.wr_data;
    end
  end

  // ---------------- sequencer ----------------
  seq_state_t     state_q [NUM_CH];
  seq_state_t     state_d [NUM_CH];
  logic [IDX_W-1:0] idx_q [NUM_CH];
  logic [IDX_W-1:0] idx_d [NUM_CH];
  logic             dir_dn_q [NUM_CH];   // 1 = ping-pong moving toward 0
  logic             dir_dn_d [NUM_CH];
  logic [D_W-1:0]   dwell_q [NUM_CH];
  logic [D_W-1:0]   dwell_d [NUM_CH];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        state_q[c]  <= S_IDLE;
        idx_q[c]    <= '0;
        dir_dn_q[c] <= 1'b0;
        dwell_q[c]  <= '0;
      end else begin
        state_q[c]  <= state_d[c];
        idx_q[c]    <= idx_d[c];
        dir_dn_q[c] <= dir_dn_d[c];
        dwell_q[c]  <= dwell_d[c];
      end
    end
  end

  always_comb begin
    logic [D_W-1:0] target;
    target = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]  = state_q[c];
      idx_d[c]    = idx_q[c];
      dir_dn_d[c] = dir_dn_q[c];
      dwell_d[c]  = dwell_q[c];
      target      = (D_W'(speed[c*SPD_W +: SPD_W]) + D_W'(1)) << 1;
      if (!enable[c]) begin
        state_d[c] = S_IDLE;   // index and direction hold while disabled
      end else begin
        case (state_q[c])
          S_IDLE: begin
            state_d[c] = S_DWELL;
            dwell_d[c] = '0;
          end
          S_DWELL: begin
            if (step) begin
              // >= so a speed lowered below the running count advances now
              if (dwell_q[c] + D_W'(1) >= target) begin
                state_d[c] = S_ADVANCE;
                dwell_d[c] = '0;
              end else begin
                dwell_d[c] = dwell_q[c] + D_W'(1);
              end
            end
          end
          S_ADVANCE: begin
            state_d[c] = S_DWELL;
            if (!mode[c]) begin
              idx_d[c] = idx_q[c] + IDX_W'(1);   // power-of-two table wraps
            end else if (!dir_dn_q[c]) begin
              if (idx_q[c] == IDX_W'(NUM_ANGLES - 1)) begin
                dir_dn_d[c] = 1'b1;
                idx_d[c]    = idx_q[c] - IDX_W'(1);
              end else begin
                idx_d[c] = idx_q[c] + IDX_W'(1);
              end
            end else begin
              if (idx_q[c] == '0) begin
                dir_dn_d[c] = 1'b0;
                idx_d[c]    = idx_q[c] + IDX_W'(1);
              end else begin
                idx_d[c] = idx_q[c] - IDX_W'(1);
              end
            end
          end
          default: state_d[c] = S_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_idx
    assign angle_idx[g*IDX_W +: IDX_W] = idx_q[g];
  end

  // ---------------- width latch and PWM ----------------
  logic [WL_W-1:0] width_sel [NUM_CH];
  logic [WL_W-1:0] width_lat [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      width_sel[c] = (32'(width_tbl[c][idx_q[c]]) >= 32'(PERIOD_TICKS))
                     ? WL_W'(PERIOD_TICKS) : WL_W'(width_tbl[c][idx_q[c]]);
    end
  end

  // A table write in the wrap clk is not yet visible here, so the latch
  // takes the old value and the new one applies from the next frame.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        width_lat[c] <= '0;
        pwm_out[c]   <= 1'b0;
      end else begin
        if (frame_wrap) width_lat[c] <= width_sel[c];
        pwm_out[c] <= enable[c] & (32'(frame_cnt) < 32'(width_lat[c]));
      end
    end
  end
endmodule
